// File: rtl/error_report_source_pkg.sv
// Shared definitions for the error-report stream: record type codes, field
// widths/positions and the packed 64-bit record layout.
package error_report_source_pkg;

   typedef enum logic [3:0] {
      TYPE_NONE = 4'd0,
      TYPE_ECC  = 4'd1,
      TYPE_CRAM = 4'd2,
      TYPE_SYS  = 4'd3
   } rec_type_e;

   localparam int TYPE_W   = 4;
   localparam int SEQ_W    = 12;
   localparam int TS_W     = 16;
   localparam int INFO_W   = 32;
   localparam int REC_W    = TYPE_W + SEQ_W + TS_W + INFO_W;

   localparam int TYPE_LSB = 60;
   localparam int SEQ_LSB  = 48;
   localparam int TS_LSB   = 32;
   localparam int INFO_LSB = 0;

   typedef struct packed {
      rec_type_e          typ;
      logic [SEQ_W-1:0]   seq;
      logic [TS_W-1:0]    ts;
      logic [INFO_W-1:0]  info;
   } record_t;

endpackage

// File: rtl/error_report_source_fifo.sv
// report_fifo: synchronous show-ahead FIFO with registered full/empty flags.
// Reads and writes arriving while empty/full are ignored.
module report_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wptr_q, wptr_d;
   logic [AW:0]       rptr_q, rptr_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              wr_ok, rd_ok;

   always_comb begin
      wr_ok   = wr_en_i && !full_q;
      rd_ok   = rd_en_i && !empty_q;
      wptr_d  = wptr_q + {{AW{1'b0}}, wr_ok};
      rptr_d  = rptr_q + {{AW{1'b0}}, rd_ok};
      empty_d = (wptr_d == rptr_d);
      // Same slot index with the wrap bits differing means the writer lapped the reader.
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
   end

   // Stale storage is masked so the output reads 0 whenever nothing is queued.
   assign rd_data_o = empty_q ? '0 : mem_q[rptr_q[AW-1:0]];
   assign full_o    = full_q;
   assign empty_o   = empty_q;

endmodule

// File: rtl/error_report_source.sv
// Error-report producer: per-source pending capture, fixed-priority arbiter,
// sequenced records into a FIFO. Optional timestamp: ERROR_REPORT_TIMESTAMP_EN.
module error_report_source
   import error_report_source_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        eccStatus,
   input  logic        cramErr,
   input  logic        sysErr,
   input  logic [31:0] errInfo,
   output logic [63:0] srcData,
   output logic        srcValid,
   input  logic        srcReady,
   output logic [15:0] dropCount
);

   localparam int DROP_W = 16;

   function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] a,
                                                      input logic [1:0]        b);
      logic [DROP_W:0] s;
      s = {1'b0, a} + {{(DROP_W-1){1'b0}}, b};
      return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
   endfunction

   logic              ecc_pend_q, ecc_pend_d;
   logic              cram_pend_q, cram_pend_d;
   logic              sys_pend_q, sys_pend_d;
   logic [INFO_W-1:0] cram_info_q, cram_info_d;
   logic [INFO_W-1:0] sys_info_q, sys_info_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [TS_W-1:0]   ts;
   logic [1:0]        drop_n;
   logic              wr_sys, wr_cram, wr_ecc, wr_en;
   record_t           wr_rec;
   logic              fifo_full, fifo_empty;
   logic [REC_W-1:0]  rd_data;

`ifdef ERROR_REPORT_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + TS_W'(1);
   end
   assign ts = ts_q;
`else
   assign ts = '0;
`endif

   always_comb begin
      wr_sys  = !fifo_full && sys_pend_q;
      wr_cram = !fifo_full && cram_pend_q && !sys_pend_q;
      wr_ecc  = !fifo_full && ecc_pend_q && !cram_pend_q && !sys_pend_q;
      wr_en   = wr_sys || wr_cram || wr_ecc;

      wr_rec      = '0;
      wr_rec.seq  = seq_q;
      wr_rec.ts   = ts;
      if (wr_sys) begin
         wr_rec.typ  = TYPE_SYS;
         wr_rec.info = sys_info_q;
      end else if (wr_cram) begin
         wr_rec.typ  = TYPE_CRAM;
         wr_rec.info = cram_info_q;
      end else if (wr_ecc) begin
         wr_rec.typ  = TYPE_ECC;
      end

      // A write clears pending; a new event can only set it when it was clear.
      ecc_pend_d  = (ecc_pend_q && !wr_ecc) || (eccStatus && !ecc_pend_q);
      cram_pend_d = (cram_pend_q && !wr_cram) || (cramErr && !cram_pend_q);
      sys_pend_d  = (sys_pend_q && !wr_sys) || (sysErr && !sys_pend_q);
      cram_info_d = (cramErr && !cram_pend_q) ? errInfo : cram_info_q;
      sys_info_d  = (sysErr && !sys_pend_q) ? errInfo : sys_info_q;

      seq_d  = wr_en ? seq_q + SEQ_W'(1) : seq_q;
      drop_n = {1'b0, eccStatus & ecc_pend_q} + {1'b0, cramErr & cram_pend_q}
             + {1'b0, sysErr & sys_pend_q};
      drop_d = drop_sat_add(drop_q, drop_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ecc_pend_q  <= 1'b0;
         cram_pend_q <= 1'b0;
         sys_pend_q  <= 1'b0;
         cram_info_q <= '0;
         sys_info_q  <= '0;
         seq_q       <= '0;
         drop_q      <= '0;
      end else begin
         ecc_pend_q  <= ecc_pend_d;
         cram_pend_q <= cram_pend_d;
         sys_pend_q  <= sys_pend_d;
         cram_info_q <= cram_info_d;
         sys_info_q  <= sys_info_d;
         seq_q       <= seq_d;
         drop_q      <= drop_d;
      end
   end

   report_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (REC_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_rec),
      .rd_en_i   (srcReady),
      .rd_data_o (rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign srcData   = rd_data;
   assign srcValid  = !fifo_empty;
   assign dropCount = drop_q;

endmodule
